// File: rtl/fifo_dispatcher_if.sv
// Handshake bundle between the upstream word source, the dispatcher and the four downstream FIFOs.
// master = upstream/FIFO side that drives words and almost_full; slave = dispatcher.
// Backpressure: ready_out/almost_full carry flow control; push is a write strobe with no handshake.
interface fifo_dispatcher_if #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) ();
    logic [DATA_W-1:0]  data_in;
    logic               valid_in;
    logic               ready_out;
    logic [3:0]         almost_full;
    logic [3:0]         push;
    logic [DATA_W-1:0]  data_out;
    logic [4*CNT_W-1:0] push_cnt;
    logic               stall;

    modport master (
        output data_in, valid_in, almost_full,
        input  ready_out, push, data_out, push_cnt, stall
    );

    modport slave (
        input  data_in, valid_in, almost_full,
        output ready_out, push, data_out, push_cnt, stall
    );
endinterface

// File: rtl/fifo_dispatcher.sv
// Routes each input word to one of four FIFOs by the ID in its top two bits, counting pushes per queue.
// Latency: one cycle from accept to push when the destination FIFO is not almost full.
// Backpressure: ready_out drops only while the held word's own FIFO is almost full.
module fifo_dispatcher #(
    parameter int DATA_W = 6,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_L,
    fifo_dispatcher_if.slave  dsp
);
    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HELD  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_hold_data;
    logic [3:0]        r_push;
    logic [DATA_W-1:0] r_data_out;
    logic              r_stall;
    logic [CNT_W-1:0]  r_cnt [4];

    logic [1:0]        w_dest;
    logic              w_held;
    logic              w_drain;
    logic              w_ready;
    logic              w_accept;

    // A held word with its FIFO almost full is the BLOCKED condition; otherwise it drains.
    assign w_dest   = r_hold_data[DATA_W-1 -: 2];
    assign w_held   = (r_state == S_HELD);
    assign w_drain  = w_held & ~dsp.almost_full[w_dest];
    assign w_ready  = ~w_held | w_drain;
    assign w_accept = dsp.valid_in & w_ready;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_accept)              w_state_nxt = S_HELD;
            S_HELD:  if (w_drain && !w_accept)  w_state_nxt = S_EMPTY;
            default:                            w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_hold_data <= '0;
            r_push      <= 4'b0000;
            r_data_out  <= '0;
            r_stall     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_hold_data <= dsp.data_in;
            end
            r_push  <= w_drain ? (4'b0001 << w_dest) : 4'b0000;
            r_stall <= w_held & ~w_drain;
            if (w_drain) begin
                r_data_out     <= r_hold_data;
                r_cnt[w_dest]  <= r_cnt[w_dest] + CNT_W'(1);
            end
        end
    end

    assign dsp.ready_out = w_ready;
    assign dsp.push      = r_push;
    assign dsp.data_out  = r_data_out;
    assign dsp.stall     = r_stall;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        assign dsp.push_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
endmodule

// File: tb/tb_fifo_dispatcher.sv
// Random and directed stimulus against a one-slot queue reference model; pushes are
// scoreboarded by expected cycle, queue and data, with ready/stall/counts checked every cycle.
module tb_fifo_dispatcher;
    localparam int DW = 6;
    localparam int CW = 8;

    typedef struct {
        int              cyc;
        int              q;
        logic [DW-1:0]   d;
    } exp_t;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    fifo_dispatcher_if #(.DATA_W(DW), .CNT_W(CW)) dif ();

    fifo_dispatcher #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .dsp     (dif)
    );

    exp_t          exp_q[$];
    logic [DW-1:0] hold_q[$];
    int            cnt[4];
    bit            exp_stall;
    bit            last_acc;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [4*CW-1:0] cnt_vec();
        return {8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
    endfunction

    // Monitor: every push the DUT presents must match the oldest expected one.
    always @(negedge clk) begin
        exp_t e;
        if (reset_L === 1'b1 && dif.push !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("unexpected_push", 64'(dif.push), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("push_cycle", 64'(cyc), 64'(e.cyc));
                check("push_onehot", 64'(dif.push), 64'(4'b0001 << e.q));
                check("data_out", 64'(dif.data_out), 64'(e.d));
            end
        end
    end

    // One clock of stimulus; the model decides what the coming edge must do.
    task automatic step(input bit v, input logic [DW-1:0] d, input logic [3:0] af);
        bit            drain;
        bit            rdy;
        logic [DW-1:0] w;
        int            q;
        #1;
        dif.valid_in    = v;
        dif.data_in     = d;
        dif.almost_full = af;
        #6;
        w     = (hold_q.size() > 0) ? hold_q[0] : '0;
        q     = int'(w[DW-1 -: 2]);
        drain = (hold_q.size() > 0) && !af[q];
        rdy   = (hold_q.size() == 0) || drain;
        check("ready_out", 64'(dif.ready_out), 64'(rdy));
        check("stall", 64'(dif.stall), 64'(exp_stall));
        check("push_cnt", 64'(dif.push_cnt), 64'(cnt_vec()));
        exp_stall = (hold_q.size() > 0) && !drain;
        if (drain) begin
            void'(hold_q.pop_front());
            exp_q.push_back('{cyc + 1, q, w});
            cnt[q] = (cnt[q] + 1) % 256;
        end
        last_acc = v && rdy;
        if (last_acc) hold_q.push_back(d);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_L         = 1'b0;
        dif.valid_in    = 1'b1;
        dif.data_in     = DW'($urandom);
        dif.almost_full = 4'b0000;
        hold_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        exp_stall = 1'b0;
        #1;
        check("rst_push", 64'(dif.push), 64'd0);
        check("rst_ready", 64'(dif.ready_out), 64'd1);
        check("rst_push_cnt", 64'(dif.push_cnt), 64'd0);
        check("rst_stall", 64'(dif.stall), 64'd0);
        check("rst_data_out", 64'(dif.data_out), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_L      = 1'b1;
        dif.valid_in = 1'b0;
    endtask

    initial begin
        bit            pv;
        logic [DW-1:0] pd;
        reset_L         = 1'b0;
        dif.valid_in    = 1'b0;
        dif.data_in     = '0;
        dif.almost_full = 4'b0000;
        pv              = 1'b0;
        pd              = '0;

        do_reset();

        // Back-to-back stream over all four queues.
        for (int i = 0; i < 4; i++) step(1'b1, {2'(i), 4'($urandom)}, 4'b0000);
        repeat (2) step(1'b0, '0, 4'b0000);

        // Blocked on queue 2, then released.
        step(1'b1, {2'd2, 4'h5}, 4'b0000);
        repeat (3) step(1'b0, '0, 4'b0100);
        repeat (2) step(1'b0, '0, 4'b0000);

        // Other queues' almost_full never unblocks or blocks queue 2; upstream holds its word.
        step(1'b1, {2'd2, 4'hA}, 4'b0000);
        repeat (3) step(1'b1, {2'd0, 4'h3}, 4'b0101);
        step(1'b1, {2'd0, 4'h3}, 4'b0001);
        repeat (2) step(1'b0, '0, 4'b0000);

        // Counter wrap on queue 1.
        repeat (256) step(1'b1, {2'd1, 4'($urandom)}, 4'b0000);
        repeat (2) step(1'b0, '0, 4'b0000);

        // Random traffic with sparse almost_full and upstream holding unaccepted words.
        repeat (400) begin
            if (!pv) begin
                pv = ($urandom_range(0, 2) != 0);
                pd = DW'($urandom);
            end
            step(pv, pd, 4'($urandom & $urandom));
            if (last_acc) pv = 1'b0;
        end
        repeat (3) step(1'b0, '0, 4'b0000);

        // Reset while blocked drops the held word.
        step(1'b1, {2'd3, 4'h7}, 4'b0000);
        repeat (2) step(1'b0, '0, 4'b1000);
        do_reset();
        repeat (3) step(1'b0, '0, 4'b0000);
        step(1'b1, {2'd0, 4'h1}, 4'b0000);
        repeat (3) step(1'b0, '0, 4'b0000);

        check("exp_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
